// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the 4-phase handshake transmitter.
//   hs_state_t          : handshake FSM state encoding
//   SYNC_STAGES_DEFAULT : default depth of the acknowledge synchronizer
//   CNT_W               : width of the completed-transfer counter
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2
  } hs_state_t;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned CNT_W               = 8;

endpackage

// File: rtl/ack_sync.sv
// Single-bit multi-flop synchronizer for the far-domain acknowledge.
//   clk, rst (async, active-high), ena (holds all flops when low)
//   d : asynchronous input
//   q : synchronized output, SYNC_STAGES edges behind d
module ack_sync
  import cdc_hs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else if (ena) begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a 4-phase req/ack clock-domain crossing.
//   clk, rst (async, active-high), ena (freezes the block when low)
//   src_data/src_valid/src_ready : local word interface (accept = valid & ready)
//   data_out/req_out             : registered payload and request to far domain
//   ack_in                       : asynchronous acknowledge from far domain
//   done                         : one-cycle pulse per completed transfer
//   xfer_cnt                     : wrapping count of completed transfers
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [N-1:0]     src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [N-1:0]     data_out,
  output logic             req_out,
  input  logic             ack_in,
  output logic             done,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

  hs_state_t        state, state_next;
  logic             ack_s;
  logic [FILL_W-1:0] fill, fill_next;
  logic             primed;
  logic             req_next, done_next, ready_next;
  logic [N-1:0]     data_next;
  logic [CNT_W-1:0] cnt_next;

  ack_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .d   (ack_in),
    .q   (ack_s)
  );

  // After reset the synchronizer holds zeros that do not reflect ack_in.
  // src_ready is withheld until the chain has been refilled so that an ack
  // still high across reset release is seen as stale before any accept.
  assign primed = (fill == FILL_W'(SYNC_STAGES));

  always_comb begin
    state_next = state;
    req_next   = req_out;
    data_next  = data_out;
    done_next  = 1'b0;
    cnt_next   = xfer_cnt;
    fill_next  = primed ? fill : fill + FILL_W'(1);
    case (state)
      IDLE: begin
        if (src_valid && src_ready) begin
          state_next = WAIT_ACK_HI;
          req_next   = 1'b1;
          data_next  = src_data;
        end
      end
      WAIT_ACK_HI: begin
        if (ack_s) begin
          state_next = WAIT_ACK_LO;
          req_next   = 1'b0;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s) begin
          state_next = IDLE;
          done_next  = 1'b1;
          cnt_next   = xfer_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
    ready_next = (state_next == IDLE) && !ack_s && primed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_out   <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
      xfer_cnt  <= '0;
      src_ready <= 1'b0;
      fill      <= '0;
    end else if (ena) begin
      state     <= state_next;
      req_out   <= req_next;
      data_out  <= data_next;
      done      <= done_next;
      xfer_cnt  <= cnt_next;
      src_ready <= ready_next;
      fill      <= fill_next;
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
module tb_cdc_hs_tx;

  logic       clk = 1'b0;
  logic       rst, ena, src_valid, ack_in;
  logic [7:0] src_data, data_out, xfer_cnt;
  logic       src_ready, req_out, done;

  int tests = 0;
  int fails = 0;

  cdc_hs_tx #(.N(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .data_out  (data_out),
    .req_out   (req_out),
    .ack_in    (ack_in),
    .done      (done),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ack;
    logic       ready;
    logic       req;
    logic [7:0] dout;
    logic       dn;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic a,
                              input logic r, input logic q, input logic [7:0] o,
                              input logic dn, input logic [7:0] c);
    vec_t t;
    t.valid = v; t.data = d; t.ack = a;
    t.ready = r; t.req = q; t.dout = o; t.dn = dn; t.cnt = c;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ack_level, input string tag);
    rst = 1'b1; ena = 1'b1; src_valid = 1'b0; src_data = 8'h00; ack_in = ack_level;
    #1;
    chk({tag, " rst ready"}, src_ready, 0);
    chk({tag, " rst req"},   req_out,   0);
    chk({tag, " rst data"},  data_out,  0);
    chk({tag, " rst done"},  done,      0);
    chk({tag, " rst cnt"},   xfer_cnt,  0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Randomised wrap test state
  logic [7:0] q_words[$];
  logic [7:0] acc_word, exp_word;
  int done_seen, rise_age, fall_age, wait_rise, wait_fall, cyc;
  bit acc_pending;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Basic transfer with data-hold: one row per clock edge.
    tbl[0]  = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    tbl[2]  = mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
    tbl[3]  = mk(1, 8'hA5, 0, 0, 1, 8'hA5, 0, 0);
    tbl[4]  = mk(1, 8'h3C, 0, 0, 1, 8'hA5, 0, 0);
    tbl[5]  = mk(1, 8'h3C, 0, 0, 1, 8'hA5, 0, 0);
    tbl[6]  = mk(1, 8'h3C, 1, 0, 1, 8'hA5, 0, 0);
    tbl[7]  = mk(1, 8'h3C, 1, 0, 1, 8'hA5, 0, 0);
    tbl[8]  = mk(1, 8'h3C, 1, 0, 0, 8'hA5, 0, 0);
    tbl[9]  = mk(1, 8'h3C, 1, 0, 0, 8'hA5, 0, 0);
    tbl[10] = mk(1, 8'h3C, 1, 0, 0, 8'hA5, 0, 0);
    tbl[11] = mk(1, 8'h3C, 0, 0, 0, 8'hA5, 0, 0);
    tbl[12] = mk(1, 8'h3C, 0, 0, 0, 8'hA5, 0, 0);
    tbl[13] = mk(0, 8'h3C, 0, 1, 0, 8'hA5, 1, 1);
    tbl[14] = mk(0, 8'h3C, 0, 1, 0, 8'hA5, 0, 1);

    do_reset(1'b0, "basic");
    for (int i = 0; i < 15; i++) begin
      src_valid = tbl[i].valid;
      src_data  = tbl[i].data;
      ack_in    = tbl[i].ack;
      step();
      chk($sformatf("row%0d ready", i), src_ready, tbl[i].ready);
      chk($sformatf("row%0d req", i),   req_out,   tbl[i].req);
      chk($sformatf("row%0d data", i),  data_out,  tbl[i].dout);
      chk($sformatf("row%0d done", i),  done,      tbl[i].dn);
      chk($sformatf("row%0d cnt", i),   xfer_cnt,  tbl[i].cnt);
    end

    // Stale ack held across reset release.
    do_reset(1'b1, "stale");
    src_valid = 1'b1; src_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stale hold%0d ready", i), src_ready, 0);
      chk($sformatf("stale hold%0d req", i),   req_out,   0);
    end
    ack_in = 1'b0;
    step(); chk("stale e0 ready", src_ready, 0);
    step(); chk("stale e1 ready", src_ready, 0);
    step(); chk("stale e2 ready", src_ready, 1); chk("stale e2 req", req_out, 0);
    step(); chk("stale accept req", req_out, 1); chk("stale accept data", data_out, 8'h77);
    src_valid = 1'b0; ack_in = 1'b1;
    step(); chk("mid ack e0 req", req_out, 1);
    step(); chk("mid ack e1 req", req_out, 1);
    step(); chk("mid ack e2 req", req_out, 0);

    // Reset while waiting for ack low, ack still high afterwards.
    #2 rst = 1'b1;
    #1;
    chk("midrst req",   req_out,   0);
    chk("midrst data",  data_out,  0);
    chk("midrst done",  done,      0);
    chk("midrst cnt",   xfer_cnt,  0);
    chk("midrst ready", src_ready, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("midrst after%0d done", i),  done,      0);
      chk($sformatf("midrst after%0d ready", i), src_ready, 0);
      chk($sformatf("midrst after%0d req", i),   req_out,   0);
    end
    ack_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst clr%0d done", i), done, 0);
      chk($sformatf("midrst clr%0d cnt", i),  xfer_cnt, 0);
    end
    chk("midrst clr ready", src_ready, 1);

    // Enable freeze while ack rises in WAIT_ACK_HI.
    src_valid = 1'b1; src_data = 8'h5A;
    step(); chk("frz accept req", req_out, 1); chk("frz accept data", data_out, 8'h5A);
    src_valid = 1'b0; ena = 1'b0; ack_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("frz off%0d req", i),  req_out,  1);
      chk($sformatf("frz off%0d done", i), done,     0);
      chk($sformatf("frz off%0d data", i), data_out, 8'h5A);
    end
    ena = 1'b1;
    step(); chk("frz on e0 req", req_out, 1);
    step(); chk("frz on e1 req", req_out, 1);
    step(); chk("frz on e2 req", req_out, 0);
    ack_in = 1'b0;
    step(); chk("frz fall e0 done", done, 0);
    step(); chk("frz fall e1 done", done, 0);
    step(); chk("frz fall e2 done", done, 1); chk("frz cnt", xfer_cnt, 1);

    // 256 transfers against a random-latency responder and a payload queue.
    do_reset(1'b0, "wrap");
    done_seen = 0; rise_age = -1; fall_age = -1; wait_rise = -1; wait_fall = -1;
    cyc = 0; acc_pending = 0;
    while (cyc < 20000) begin
      step();
      cyc++;
      if (acc_pending) begin
        chk("rnd accept req", req_out, 1);
        chk("rnd accept data", data_out, acc_word);
        acc_pending = 0;
      end
      if (rise_age >= 0) begin
        rise_age++;
        if (rise_age == 2) chk("rnd req before fall", req_out, 1);
        if (rise_age == 3) begin
          chk("rnd req fall", req_out, 0);
          rise_age = -1;
        end
      end
      if (fall_age >= 0) begin
        fall_age++;
        if (fall_age < 3) chk("rnd early done", done, 0);
        else begin
          chk("rnd done", done, 1);
          fall_age = -1;
        end
      end
      if (done) begin
        if (q_words.size() == 0) chk("rnd spurious done", done, 0);
        else begin
          exp_word = q_words.pop_front();
          done_seen++;
          chk("rnd payload", data_out, exp_word);
          chk("rnd cnt", xfer_cnt, 32'(done_seen % 256));
        end
      end
      if (done_seen >= 256) break;
      src_data  = 8'($urandom);
      src_valid = ($urandom_range(0, 7) != 0);
      if (src_ready && src_valid) begin
        q_words.push_back(src_data);
        acc_word = src_data;
        acc_pending = 1;
      end
      if (req_out && !ack_in && wait_rise < 0) wait_rise = $urandom_range(0, 4);
      if (wait_rise >= 0) begin
        if (wait_rise == 0) begin
          ack_in = 1'b1; rise_age = 0; wait_rise = -1;
        end else wait_rise--;
      end
      if (!req_out && ack_in && wait_fall < 0) wait_fall = $urandom_range(0, 4);
      if (wait_fall >= 0) begin
        if (wait_fall == 0) begin
          ack_in = 1'b0; fall_age = 0; wait_fall = -1;
        end else wait_fall--;
      end
    end
    src_valid = 1'b0;
    chk("rnd transfers", done_seen, 256);
    chk("rnd final cnt", xfer_cnt, 0);
    chk("rnd leftover", q_words.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx.md
CDC_HS_TX -- requirements
Module: cdc_hs_tx

Interface
REQ-001 Parameter N, default 8, SHALL set the payload width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, SHALL set the ack synchronizer depth.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port ena, input, 1, SHALL enable the block; when low, all registers hold.
REQ-006 Port src_data, input, N, SHALL carry the word to transfer.
REQ-007 Port src_valid, input, 1, SHALL mark src_data valid.
REQ-008 Port src_ready, output, 1, SHALL indicate the block can accept a word.
REQ-009 Port data_out, output, N, SHALL be the registered payload driven to the far domain.
REQ-010 Port req_out, output, 1, SHALL be the registered 4-phase request to the far domain.
REQ-011 Port ack_in, input, 1, SHALL be the asynchronous acknowledge from the far domain.
REQ-012 Port done, output, 1, SHALL pulse for one cycle when a transfer completes.
REQ-013 Port xfer_cnt, output, 8, SHALL count completed transfers.

Function
REQ-014 ack_in SHALL pass through SYNC_STAGES flops to form ack_s; no logic SHALL use ack_in directly.
REQ-015 The FSM SHALL have states IDLE, WAIT_ACK_HI and WAIT_ACK_LO.
REQ-016 src_ready SHALL be high only in IDLE with ack_s=0; it SHALL be a registered output.
REQ-017 Accept = ena & src_valid & src_ready at an edge; data_out SHALL load src_data, req_out SHALL go 1 and the state SHALL become WAIT_ACK_HI, all visible at that edge.
REQ-018 data_out SHALL be stable from accept until the FSM returns to IDLE.
REQ-019 In WAIT_ACK_HI with ack_s=1, req_out SHALL go 0 and the state SHALL become WAIT_ACK_LO at the next edge.
REQ-020 In WAIT_ACK_LO with ack_s=0, the state SHALL become IDLE, done SHALL be 1 for exactly one cycle, and xfer_cnt SHALL increment, wrapping 255->0.
REQ-021 With SYNC_STAGES=2, ack_in rising before edge E0 SHALL give req_out=0 after edge E2; ack_in falling before edge E0 SHALL give done=1 after edge E2.
REQ-022 src_ready SHALL fall in the cycle after accept, so back-to-back accepts are impossible.
REQ-023 src_valid SHALL be ignored outside IDLE; src_data changes outside IDLE SHALL not affect data_out.
REQ-024 While ena=0, the FSM, synchronizer, outputs and counter SHALL hold; done SHALL be forced to 0.
REQ-025 In IDLE with ack_s=1 (stale ack), the block SHALL wait with src_ready=0 until ack_s=0.

Reset
REQ-026 While rst=1, the block SHALL force these values asynchronously: state IDLE, req_out 0, data_out 0, done 0, xfer_cnt 0, synchronizer flops 0, src_ready 0.
REQ-027 src_ready SHALL rise no earlier than the first clk edge after rst deasserts.
REQ-028 A reset in the middle of a transfer SHALL abort it without a done pulse or count increment; a still-high ack_in SHALL be handled per REQ-025.

Structure
REQ-029 Package cdc_hs_pkg SHALL hold the FSM state enum and the SYNC_STAGES default constant.
REQ-030 The synchronizer SHALL be the sub-module ack_sync: 1 bit, SYNC_STAGES flops, with rst and ena.
REQ-031 The RTL SHALL be 120-400 lines with no latches and all outputs registered.

Verification
REQ-032 Basic transfer: rst pulse; src_data=8'hA5 with src_valid=1; a responder sets ack_in 3 cycles after req_out and clears it 3 cycles after req_out falls -> data_out=A5 through WAIT_ACK_LO, req_out drops 2 edges after ack_in rises, one done pulse, xfer_cnt=1.
REQ-033 Data hold: src_data changes to 8'h3C while in WAIT_ACK_HI -> data_out stays A5 and src_ready stays 0.
REQ-034 Stale ack: ack_in=1 across reset release -> src_ready=0 until 2 edges after ack_in falls, and no req_out.
REQ-035 Mid-transfer reset: assert rst in WAIT_ACK_LO -> req_out=0 and data_out=0 immediately, no done pulse, xfer_cnt=0.
REQ-036 Enable freeze: ena=0 for 5 cycles in WAIT_ACK_HI while ack_in rises -> state and req_out hold; req_out falls 2 enabled edges after ena returns.
REQ-037 Wrap: 256 back-to-back transfers with a random-latency responder -> 256 done pulses, xfer_cnt=0, every payload matches.
